// File: rtl/thermometer_spi_pkg.sv
// Shared definitions for the thermometer SPI link (responder and handler).
// Holds word geometry, the temperature field position, the responder
// state encoding and the default word served before any temperature load.
package thermometer_spi_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned TEMP_MSB = 14;
    localparam int unsigned TEMP_LSB = 5;
    localparam int unsigned TEMP_W   = TEMP_MSB - TEMP_LSB + 1;

    localparam logic [WORD_W-1:0] RESET_WORD = 16'h0000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Extract the temperature field from a full SPI word.
    function automatic logic [TEMP_W-1:0] temp_field(input logic [WORD_W-1:0] word);
        return word[TEMP_MSB:TEMP_LSB];
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift the raw input in at bit 0; the synchronized value exits at the top.
    always_comb begin
        sync_d = (sync_q << 1) | DEPTH'(d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_responder_thermometer.sv
// SPI responder (CPOL=1, CPHA=1) acting as the thermometer on the link.
// Serves a snapshot of the temperature word MSB first on o_spi_so and
// captures the handler's 16-bit word from i_spi_si.
// Ports:
//   i_clk, i_reset_n              system clock, async active-low reset
//   i_spi_clk/i_spi_cs_n/i_spi_si SPI pins from the handler (asynchronous)
//   o_spi_so                      serial data to the handler, 0 when idle
//   i_temp_data/i_temp_valid      temperature word load strobe
//   o_busy                        transfer in progress
//   o_rx_word/o_rx_valid          last complete received word + update pulse
//   o_xfer_done                   pulse at the end of every transfer
module spi_responder_thermometer
    import thermometer_spi_pkg::state_e;
    import thermometer_spi_pkg::ST_IDLE;
    import thermometer_spi_pkg::ST_ACTIVE;
#(
    parameter int unsigned              WORD_W      = thermometer_spi_pkg::WORD_W,
    parameter logic [WORD_W-1:0]        RESET_WORD  = WORD_W'(thermometer_spi_pkg::RESET_WORD),
    parameter int unsigned              SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_spi_clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_si,
    output logic              o_spi_so,
    input  logic [WORD_W-1:0] i_temp_data,
    input  logic              i_temp_valid,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_rx_word,
    output logic              o_rx_valid,
    output logic              o_xfer_done
);

    localparam int unsigned       CNT_W    = $clog2(WORD_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WORD_W + 1);

    logic sck_s;
    logic cs_n_s;
    logic si_s;

    state_e            state_q,      state_d;
    logic              sck_prev_q,   sck_prev_d;
    logic              cs_n_prev_q,  cs_n_prev_d;
    logic [WORD_W-1:0] temp_q,       temp_d;
    logic [WORD_W-1:0] pend_q,       pend_d;
    logic              pend_vld_q,   pend_vld_d;
    logic [WORD_W-1:0] shift_q,      shift_d;
    logic [WORD_W-1:0] rx_shift_q,   rx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q,     tx_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q,     rx_cnt_d;
    logic              so_q,         so_d;
    logic              busy_q,       busy_d;
    logic [WORD_W-1:0] rx_word_q,    rx_word_d;
    logic              rx_valid_q,   rx_valid_d;
    logic              xfer_done_q,  xfer_done_d;

    logic sck_fall_c;
    logic sck_rise_c;
    logic cs_fall_c;
    logic cs_rise_c;

    // SCK idles high. CS resets low so that a CS held low across reset
    // release is never mistaken for a fresh falling edge.
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_spi_clk), .q(sck_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_spi_cs_n), .q(cs_n_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_si (
        .clk(i_clk), .rst_n(i_reset_n), .d(i_spi_si), .q(si_s)
    );

    assign sck_fall_c =  sck_prev_q  & ~sck_s;
    assign sck_rise_c = ~sck_prev_q  &  sck_s;
    assign cs_fall_c  =  cs_n_prev_q & ~cs_n_s;
    assign cs_rise_c  = ~cs_n_prev_q &  cs_n_s;

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sck_prev_d  = sck_s;
        cs_n_prev_d = cs_n_s;
        temp_d      = temp_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        shift_d     = shift_q;
        rx_shift_d  = rx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        so_d        = so_q;
        busy_d      = busy_q;
        rx_word_d   = rx_word_q;
        rx_valid_d  = 1'b0;
        xfer_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_temp_valid) begin
                    temp_d = i_temp_data;
                end
                // Snapshot uses the pre-load word when both happen together.
                if (cs_fall_c) begin
                    state_d  = ST_ACTIVE;
                    shift_d  = temp_q;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    so_d     = temp_q[WORD_W-1];
                    busy_d   = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (i_temp_valid) begin
                    pend_d     = i_temp_data;
                    pend_vld_d = 1'b1;
                end
                if (cs_rise_c) begin
                    // End of transfer wins over any coincident SCK edge.
                    state_d     = ST_IDLE;
                    xfer_done_d = 1'b1;
                    so_d        = 1'b0;
                    busy_d      = 1'b0;
                    pend_vld_d  = 1'b0;
                    if (rx_cnt_q == CNT_FULL) begin
                        rx_word_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                    if (i_temp_valid) begin
                        temp_d = i_temp_data;
                    end else if (pend_vld_q) begin
                        temp_d = pend_q;
                    end
                end else begin
                    // Shift register drains MSB first; zeros fill once it is empty.
                    if (sck_fall_c) begin
                        so_d     = (tx_cnt_q < CNT_FULL) ? shift_q[WORD_W-1] : 1'b0;
                        shift_d  = shift_q << 1;
                        tx_cnt_d = (tx_cnt_q == CNT_MAX) ? tx_cnt_q : tx_cnt_q + CNT_W'(1);
                    end
                    if (sck_rise_c) begin
                        rx_shift_d = {rx_shift_q[WORD_W-2:0], si_s};
                        rx_cnt_d   = (rx_cnt_q == CNT_MAX) ? rx_cnt_q : rx_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            sck_prev_q  <= 1'b1;
            cs_n_prev_q <= 1'b0;
            temp_q      <= RESET_WORD;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            shift_q     <= '0;
            rx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            so_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_prev_q  <= sck_prev_d;
            cs_n_prev_q <= cs_n_prev_d;
            temp_q      <= temp_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            shift_q     <= shift_d;
            rx_shift_q  <= rx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            so_q        <= so_d;
            busy_q      <= busy_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign o_spi_so    = so_q;
    assign o_busy      = busy_q;
    assign o_rx_word   = rx_word_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_xfer_done = xfer_done_q;

endmodule

// File: tb/tb_spi_responder_thermometer.sv
// Directed bench for spi_responder_thermometer: a CPOL=1/CPHA=1 master
// task drives CS/SCK/SI, samples SO on rising SCK, and can inject a
// temperature load or a reset at a chosen bit.
module tb_spi_responder_thermometer;
    import thermometer_spi_pkg::temp_field;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_spi_clk;
    logic        i_spi_cs_n;
    logic        i_spi_si;
    logic        o_spi_so;
    logic [15:0] i_temp_data;
    logic        i_temp_valid;
    logic        o_busy;
    logic [15:0] o_rx_word;
    logic        o_rx_valid;
    logic        o_xfer_done;

    int n_checks = 0;
    int n_fail   = 0;
    int rv_cnt   = 0;
    int xd_cnt   = 0;

    logic [31:0] samples;
    int          rv_delta;
    int          xd_delta;
    logic        busy_end;

    spi_responder_thermometer dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_spi_clk    (i_spi_clk),
        .i_spi_cs_n   (i_spi_cs_n),
        .i_spi_si     (i_spi_si),
        .o_spi_so     (o_spi_so),
        .i_temp_data  (i_temp_data),
        .i_temp_valid (i_temp_valid),
        .o_busy       (o_busy),
        .o_rx_word    (o_rx_word),
        .o_rx_valid   (o_rx_valid),
        .o_xfer_done  (o_xfer_done)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_rx_valid)  rv_cnt = rv_cnt + 1;
        if (o_xfer_done) xd_cnt = xd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        i_temp_data  = v;
        i_temp_valid = 1'b1;
        tick(1);
        i_temp_valid = 1'b0;
        tick(2);
    endtask

    // One CS window of nclk SCK cycles. load_at: -1 = load on the
    // synchronized CS-fall cycle, 0..nclk-1 = load during that bit, else none.
    task automatic xfer(input logic [15:0] tx, input int nclk,
                        input int load_at, input logic [15:0] load_val,
                        input int reset_at,
                        output logic [31:0] so_bits, output int rv_d,
                        output int xd_d, output logic busy_pre_rise);
        int rv0;
        int xd0;
        rv0     = rv_cnt;
        xd0     = xd_cnt;
        so_bits = '0;
        i_spi_cs_n = 1'b0;
        tick(2);
        check("busy_lat2", 32'(o_busy), 32'd0);
        if (load_at == -1) begin
            i_temp_data  = load_val;
            i_temp_valid = 1'b1;
        end
        tick(1);
        i_temp_valid = 1'b0;
        check("busy_lat3", 32'(o_busy), 32'd1);
        tick(5);
        for (int i = 0; i < nclk; i++) begin
            i_spi_clk = 1'b0;
            i_spi_si  = (i < 16) ? tx[15-i] : 1'b0;
            if (i == load_at) begin
                i_temp_data  = load_val;
                i_temp_valid = 1'b1;
                tick(1);
                i_temp_valid = 1'b0;
                tick(7);
            end else if (i == reset_at) begin
                i_reset_n = 1'b0;
                tick(2);
                i_reset_n = 1'b1;
                tick(6);
            end else begin
                tick(8);
            end
            so_bits   = {so_bits[30:0], o_spi_so};
            i_spi_clk = 1'b1;
            tick(8);
        end
        busy_pre_rise = o_busy;
        i_spi_cs_n = 1'b1;
        i_spi_si   = 1'b0;
        tick(8);
        rv_d = rv_cnt - rv0;
        xd_d = xd_cnt - xd0;
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_spi_clk    = 1'b1;
        i_spi_cs_n   = 1'b1;
        i_spi_si     = 1'b0;
        i_temp_data  = 16'h0000;
        i_temp_valid = 1'b0;
        tick(3);
        check("rst_so",        32'(o_spi_so),    32'd0);
        check("rst_busy",      32'(o_busy),      32'd0);
        check("rst_rx_word",   32'(o_rx_word),   32'd0);
        check("rst_rx_valid",  32'(o_rx_valid),  32'd0);
        check("rst_xfer_done", 32'(o_xfer_done), 32'd0);
        i_reset_n = 1'b1;
        tick(5);

        // Read with no load; handler sends A5C3.
        xfer(16'hA5C3, 16, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("noload_so",   samples,          32'h0000);
        check("noload_xd",   32'(xd_delta),    32'd1);
        check("noload_rv",   32'(rv_delta),    32'd1);
        check("noload_rx",   32'(o_rx_word),   32'hA5C3);
        check("noload_busy", 32'(busy_end),    32'd1);
        check("idle_so",     32'(o_spi_so),    32'd0);
        check("idle_busy",   32'(o_busy),      32'd0);

        // Load in IDLE, then read it back.
        load(16'h2A60);
        xfer(16'h0000, 16, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("load_so",    samples,                    32'h2A60);
        check("load_field", 32'(temp_field(samples[15:0])), 32'h153);
        check("load_rx",    32'(o_rx_word),             32'h0000);

        // Load mid-transfer: current read keeps its snapshot.
        xfer(16'h5A5A, 16, 5, 16'h1234, 99, samples, rv_delta, xd_delta, busy_end);
        check("mid_so",  samples,        32'h2A60);
        check("mid_rx",  32'(o_rx_word), 32'h5A5A);
        xfer(16'h3C3C, 16, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("after_mid_so", samples,        32'h1234);
        check("after_mid_rx", 32'(o_rx_word), 32'h3C3C);

        // Aborted 9-bit transfer: no rx update.
        xfer(16'hFFFF, 9, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("abort_so", samples & 32'h1FF, 32'h024);
        check("abort_rv", 32'(rv_delta),     32'd0);
        check("abort_xd", 32'(xd_delta),     32'd1);
        check("abort_rx", 32'(o_rx_word),    32'h3C3C);

        // 20 clocks serving FFFF: tail bits are zero, rx count overruns.
        load(16'hFFFF);
        xfer(16'h0F0F, 20, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("over_so", samples,         32'hFFFF0);
        check("over_rv", 32'(rv_delta),   32'd0);
        check("over_xd", 32'(xd_delta),   32'd1);

        // Reset during bit 7 with CS held low.
        xfer(16'h1357, 16, 99, 16'h0, 7, samples, rv_delta, xd_delta, busy_end);
        check("rstmid_so",   samples,        32'hFE00);
        check("rstmid_rv",   32'(rv_delta),  32'd0);
        check("rstmid_xd",   32'(xd_delta),  32'd0);
        check("rstmid_busy", 32'(busy_end),  32'd0);
        check("rstmid_rx",   32'(o_rx_word), 32'h0000);
        xfer(16'h8001, 16, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("postrst_so", samples,        32'h0000);
        check("postrst_rv", 32'(rv_delta),  32'd1);
        check("postrst_rx", 32'(o_rx_word), 32'h8001);

        // Load on the same cycle as the synchronized CS fall.
        xfer(16'h1111, 16, -1, 16'h0ABC, 99, samples, rv_delta, xd_delta, busy_end);
        check("samecyc_so", samples, 32'h0000);
        xfer(16'h0000, 16, 99, 16'h0, 99, samples, rv_delta, xd_delta, busy_end);
        check("samecyc_next",  samples,                       32'h0ABC);
        check("samecyc_field", 32'(temp_field(samples[15:0])), 32'h055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
